// File: rtl/fir_pkg.sv
// Shared types for the FIR output-side blocks.
package fir_pkg;
  localparam int SIZE = 16;

  typedef logic signed [SIZE-1:0] sample_t;
  typedef logic [SIZE:0]          pkpk_t;
  typedef enum logic {EMPTY, ACC} meter_state_t;
endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector: rise is high in the first cycle a level goes high.
module strobe_edge (
  input  logic ck,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic level_q;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) level_q <= 1'b0;
    else      level_q <= level;
  end

  assign rise = level & ~level_q;
endmodule

// File: rtl/fir_pk_meter.sv
// Windowed max/min/peak-to-peak meter on the FIR output stream.
module fir_pk_meter #(
  parameter int SIZE   = 16,
  parameter int WINDOW = 64
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic signed [SIZE-1:0]        out,
  input  logic                          output_ready,
  input  logic                          clear,
  output logic signed [SIZE-1:0]        peak_max,
  output logic signed [SIZE-1:0]        peak_min,
  output logic [SIZE:0]                 pk_pk,
  output logic                          result_valid,
  output logic [$clog2(WINDOW+1)-1:0]   sample_count
);
  import fir_pkg::*;

  localparam int            CW   = $clog2(WINDOW+1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW-1);

  logic accept;

  strobe_edge u_edge (
    .ck    (ck),
    .rst   (rst),
    .level (output_ready),
    .rise  (accept)
  );

  meter_state_t           state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [SIZE-1:0] max_q, max_d, min_q, min_d;
  logic signed [SIZE-1:0] pmax_q, pmax_d, pmin_q, pmin_d;
  logic [SIZE:0]          pkpk_q, pkpk_d;
  logic                   valid_q, valid_d;
  logic signed [SIZE-1:0] nmax, nmin;

  // Running extremes including the current sample; EMPTY seeds both.
  always_comb begin
    nmax = max_q;
    nmin = min_q;
    if (state_q == EMPTY) begin
      nmax = out;
      nmin = out;
    end else begin
      if (out > max_q) nmax = out;
      if (out < min_q) nmin = out;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    pmax_d  = pmax_q;
    pmin_d  = pmin_q;
    pkpk_d  = pkpk_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (accept) begin
      max_d = nmax;
      min_d = nmin;
      if (cnt_q == LAST) begin
        pmax_d  = nmax;
        pmin_d  = nmin;
        // Sign-extend both so max-min always fits unsigned in SIZE+1 bits.
        pkpk_d  = {nmax[SIZE-1], nmax} - {nmin[SIZE-1], nmin};
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = EMPTY;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      pmax_q  <= '0;
      pmin_q  <= '0;
      pkpk_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      min_q   <= min_d;
      pmax_q  <= pmax_d;
      pmin_q  <= pmin_d;
      pkpk_q  <= pkpk_d;
      valid_q <= valid_d;
    end
  end

  assign peak_max     = pmax_q;
  assign peak_min     = pmin_q;
  assign pk_pk        = pkpk_q;
  assign result_valid = valid_q;
  assign sample_count = cnt_q;
endmodule

// File: tb/tb_fir_pk_meter.sv
// Scoreboard bench for fir_pk_meter: WINDOW=4 instance plus a default WINDOW=64 instance.
module tb_fir_pk_meter;
  localparam int W = 4;

  logic               ck = 1'b0;
  logic               rst;
  logic signed [15:0] out;
  logic               output_ready, clear;
  logic signed [15:0] peak_max, peak_min;
  logic [16:0]        pk_pk;
  logic               result_valid;
  logic [2:0]         sample_count;

  logic signed [15:0] out64;
  logic               rdy64, clr64;
  logic signed [15:0] pmax64, pmin64;
  logic [16:0]        pkpk64;
  logic               rv64;
  logic [6:0]         cnt64;

  fir_pk_meter #(.SIZE(16), .WINDOW(W)) dut (
    .ck(ck), .rst(rst), .out(out), .output_ready(output_ready), .clear(clear),
    .peak_max(peak_max), .peak_min(peak_min), .pk_pk(pk_pk),
    .result_valid(result_valid), .sample_count(sample_count)
  );

  fir_pk_meter dut64 (
    .ck(ck), .rst(rst), .out(out64), .output_ready(rdy64), .clear(clr64),
    .peak_max(pmax64), .peak_min(pmin64), .pk_pk(pkpk64),
    .result_valid(rv64), .sample_count(cnt64)
  );

  always #5 ck = ~ck;

  typedef struct { int mx; int mn; int pp; int cyc; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int m_cnt = 0, m_max = 0, m_min = 0;
  int last_mx = 0, last_mn = 0, last_pp = 0;
  int v64_n = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  // Reference model for one accepted sample.
  task automatic model_accept(input int v);
    exp_t e;
    if (m_cnt == 0) begin
      m_max = v;
      m_min = v;
    end else begin
      if (v > m_max) m_max = v;
      if (v < m_min) m_min = v;
    end
    m_cnt++;
    if (m_cnt == W) begin
      e.mx = m_max; e.mn = m_min; e.pp = m_max - m_min; e.cyc = cyc + 1;
      sb.push_back(e);
      last_mx = e.mx; last_mn = e.mn; last_pp = e.pp;
      m_cnt = 0;
    end
  endtask

  task automatic strobe(input int v, input int hold, input int gap);
    out = 16'(v);
    output_ready = 1'b1;
    model_accept(v);
    tick(hold);
    output_ready = 1'b0;
    tick(gap);
  endtask

  always @(posedge ck) cyc <= cyc + 1;

  always @(negedge ck) begin
    if (rv64) v64_n++;
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("peak_max", peak_max, e.mx);
        chk("peak_min", peak_min, e.mn);
        chk("pk_pk", pk_pk, e.pp);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    int v, mx64, mn64;
    rst = 1'b0; out = '0; output_ready = 1'b0; clear = 1'b0;
    out64 = '0; rdy64 = 1'b0; clr64 = 1'b0;
    #2;
    chk("rst_max", peak_max, 0);
    chk("rst_min", peak_min, 0);
    chk("rst_pkpk", pk_pk, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_cnt", sample_count, 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Square wave +-10000, 1-cycle strobe every 25 cycles, two windows.
    for (int i = 0; i < 8; i++) strobe((i % 2 == 0) ? 10000 : -10000, 1, 24);

    // Full-scale extremes: pk_pk must reach 65535 without wrapping.
    for (int i = 0; i < 4; i++) strobe((i % 2 == 0) ? -32768 : 32767, 1, 3);

    // Strobe held high 5 cycles: one accept per strobe.
    for (int i = 0; i < 4; i++) begin
      strobe(1234, 5, 3);
      chk("cnt_hold", sample_count, m_cnt);
    end

    // clear mid-window, then clear coinciding with a strobe edge.
    strobe(100, 1, 2);
    strobe(-100, 1, 2);
    chk("cnt_pre_clear", sample_count, 2);
    clear = 1'b1; tick(1); clear = 1'b0; m_cnt = 0; tick(1);
    chk("cnt_clear", sample_count, 0);
    chk("held_max", peak_max, last_mx);
    chk("held_min", peak_min, last_mn);
    chk("held_pkpk", pk_pk, last_pp);
    out = 16'sd9999; output_ready = 1'b1; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    output_ready = 1'b0;
    tick(2);
    chk("cnt_clear_edge", sample_count, 0);
    for (int i = 1; i <= 4; i++) begin
      strobe(i, 1, 3);
      chk("cnt_after_clear", sample_count, m_cnt);
    end

    // Asynchronous reset between clock edges mid-window.
    strobe(50, 1, 2);
    strobe(60, 1, 2);
    #3 rst = 1'b0;
    #1;
    m_cnt = 0;
    chk("arst_max", peak_max, 0);
    chk("arst_min", peak_min, 0);
    chk("arst_pkpk", pk_pk, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_cnt", sample_count, 0);
    @(posedge ck); #1;
    rst = 1'b1;
    tick(1);
    strobe(5, 1, 2);
    strobe(-7, 1, 2);
    strobe(3, 1, 2);
    strobe(0, 1, 3);

    // Back-to-back windows with dense 1-on/1-off strobes and random samples.
    for (int i = 0; i < 8; i++) strobe(int'($urandom_range(0, 65535)) - 32768, 1, 1);
    tick(4);
    chk("sb_drained", sb.size(), 0);

    // Default WINDOW=64: 5 kHz square, 40 kHz strobe at 1 MHz clock.
    mx64 = -40000; mn64 = 40000;
    for (int i = 0; i < 64; i++) begin
      v = ((i / 4) % 2 == 0) ? 10000 : -10000;
      if (v > mx64) mx64 = v;
      if (v < mn64) mn64 = v;
      if (i == 63) begin
        chk("cnt64_pre", cnt64, 63);
        chk("v64_none_yet", v64_n, 0);
      end
      out64 = 16'(v); rdy64 = 1'b1;
      tick(1);
      rdy64 = 1'b0;
      if (i < 63) tick(24);
    end
    chk("v64_valid", rv64, 1);
    chk("v64_max", pmax64, mx64);
    chk("v64_min", pmin64, mn64);
    chk("v64_pkpk", pkpk64, 20000);
    tick(1);
    chk("v64_pulse", rv64, 0);
    chk("v64_count", v64_n, 1);
    chk("cnt64_post", cnt64, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "timeout");
  end
endmodule
